// File: rtl/ha_check_pkg.sv
// Shared types and constants for the half-adder response checker.
package ha_check_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of distinct {a,b} operand pairs a half adder can see.
  localparam int NUM_COMBOS = 4;

endpackage

// File: rtl/ha_ref_model.sv
// Golden half-adder: expected carry and sum for one operand pair.
module ha_ref_model (
  input  logic a,
  input  logic b,
  output logic exp_c,
  output logic exp_s
);

  assign exp_c = a & b;
  assign exp_s = a ^ b;

endmodule

// File: rtl/ha_response_checker.sv
// Half-adder response checker: scores NUM_VECTORS observed {c,s} results
// against a reference model and reports pass/fail plus first-failure info.
// Optional feature macro: HA_CHECK_COVERAGE_EN adds the cov_map output and
// makes pass also require every {a,b} operand pair to have been exercised.
module ha_response_checker
  import ha_check_pkg::*;
#(
  parameter int NUM_VECTORS = 4,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sample_valid,
  input  logic             a,
  input  logic             b,
  input  logic             c,
  input  logic             s,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] vec_count,
  output logic [CNT_W-1:0] first_fail_idx,
  output logic [3:0]       first_fail_bits,
`ifdef HA_CHECK_COVERAGE_EN
  output logic [NUM_COMBOS-1:0] cov_map,
`endif
  output logic             fail_seen
);

  state_t state;

  logic exp_c, exp_s;

  ha_ref_model u_ref (
    .a     (a),
    .b     (b),
    .exp_c (exp_c),
    .exp_s (exp_s)
  );

  logic             mism;
  logic [CNT_W-1:0] vec_nxt;
  logic [CNT_W-1:0] err_nxt;
  logic             last_vec;
  logic             pass_nxt;

  assign mism     = (c != exp_c) || (s != exp_s);
  assign vec_nxt  = vec_count + 1'b1;
  // Saturate rather than wrap so a long failing run never reads as clean.
  assign err_nxt  = (mism && (err_count != '1)) ? err_count + 1'b1 : err_count;
  assign last_vec = (vec_nxt == CNT_W'(NUM_VECTORS));

`ifdef HA_CHECK_COVERAGE_EN
  logic [NUM_COMBOS-1:0] cov_hit;
  logic [NUM_COMBOS-1:0] cov_nxt;

  // One-hot of the operand pair being checked this cycle.
  always_comb begin
    cov_hit          = '0;
    cov_hit[{a, b}]  = 1'b1;
  end

  assign cov_nxt  = cov_map | cov_hit;
  assign pass_nxt = (err_nxt == '0) && (cov_nxt == '1);
`else
  assign pass_nxt = (err_nxt == '0);
`endif

  // Control FSM with all status outputs registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      err_count       <= '0;
      vec_count       <= '0;
      first_fail_idx  <= '0;
      first_fail_bits <= '0;
      fail_seen       <= 1'b0;
`ifdef HA_CHECK_COVERAGE_EN
      cov_map         <= '0;
`endif
    end else begin
      case (state)
        RUN: begin
          if (sample_valid) begin
            vec_count <= vec_nxt;
            err_count <= err_nxt;
`ifdef HA_CHECK_COVERAGE_EN
            cov_map   <= cov_nxt;
`endif
            if (mism && !fail_seen) begin
              first_fail_idx  <= vec_count;
              first_fail_bits <= {a, b, c, s};
              fail_seen       <= 1'b1;
            end
            if (last_vec) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= pass_nxt;
            end
          end
        end
        // IDLE and DONE behave alike: only start matters, and it rearms.
        default: begin
          if (start) begin
            state           <= RUN;
            busy            <= 1'b1;
            done            <= 1'b0;
            pass            <= 1'b0;
            err_count       <= '0;
            vec_count       <= '0;
            first_fail_idx  <= '0;
            first_fail_bits <= '0;
            fail_seen       <= 1'b0;
`ifdef HA_CHECK_COVERAGE_EN
            cov_map         <= '0;
`endif
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ha_response_checker.sv
// Directed bench for ha_response_checker: default instance plus a narrow
// CNT_W=2 / NUM_VECTORS=3 instance for the counter-limit case.
module tb_ha_response_checker;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic start_s = 1'b0;
  logic sample_valid = 1'b0;
  logic a = 1'b0, b = 1'b0, c = 1'b0, s = 1'b0;

  logic       busy, done, pass, fail_seen;
  logic [7:0] err_count, vec_count, first_fail_idx;
  logic [3:0] first_fail_bits;

  logic       busy_s, done_s, pass_s, fail_seen_s;
  logic [1:0] err_count_s, vec_count_s, first_fail_idx_s;
  logic [3:0] first_fail_bits_s;

`ifdef HA_CHECK_COVERAGE_EN
  logic [3:0] cov_map, cov_map_s;
`endif

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ha_response_checker u_dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .sample_valid    (sample_valid),
    .a               (a),
    .b               (b),
    .c               (c),
    .s               (s),
    .busy            (busy),
    .done            (done),
    .pass            (pass),
    .err_count       (err_count),
    .vec_count       (vec_count),
    .first_fail_idx  (first_fail_idx),
    .first_fail_bits (first_fail_bits),
`ifdef HA_CHECK_COVERAGE_EN
    .cov_map         (cov_map),
`endif
    .fail_seen       (fail_seen)
  );

  ha_response_checker #(.NUM_VECTORS(3), .CNT_W(2)) u_sat (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start_s),
    .sample_valid    (sample_valid),
    .a               (a),
    .b               (b),
    .c               (c),
    .s               (s),
    .busy            (busy_s),
    .done            (done_s),
    .pass            (pass_s),
    .err_count       (err_count_s),
    .vec_count       (vec_count_s),
    .first_fail_idx  (first_fail_idx_s),
    .first_fail_bits (first_fail_bits_s),
`ifdef HA_CHECK_COVERAGE_EN
    .cov_map         (cov_map_s),
`endif
    .fail_seen       (fail_seen_s)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic vec(input logic va, input logic vb, input logic vc, input logic vs);
    a = va; b = vb; c = vc; s = vs;
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
  endtask

  initial begin
    // reset state
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_vec", vec_count, 0);
    rst_n = 1'b1;
    tick();

    // sample_valid in IDLE is ignored
    vec(1, 1, 1, 0);
    chk("idle_sv_vec", vec_count, 0);
    chk("idle_sv_busy", busy, 0);

    // correct device, with a start pulse mid-run that must be ignored
    pulse_start();
    chk("s1_busy", busy, 1);
    vec(0, 0, 0, 0);
    chk("s1_vec1", vec_count, 1);
    vec(0, 1, 0, 1);
    pulse_start();
    chk("s1_midstart_vec", vec_count, 2);
    chk("s1_midstart_busy", busy, 1);
    vec(1, 0, 0, 1);
    chk("s1_done_before_last", done, 0);
    vec(1, 1, 1, 0);
    chk("s1_done", done, 1);
    chk("s1_busy_end", busy, 0);
    chk("s1_pass", pass, 1);
    chk("s1_err", err_count, 0);
    chk("s1_vec", vec_count, 4);
    chk("s1_fail_seen", fail_seen, 0);

    // injected fault on the 3rd vector, restarted from DONE
    pulse_start();
    chk("s2_clr_done", done, 0);
    chk("s2_clr_pass", pass, 0);
    chk("s2_clr_vec", vec_count, 0);
    vec(0, 0, 0, 0);
    vec(0, 1, 0, 1);
    vec(1, 1, 0, 0);
    vec(1, 0, 0, 1);
    chk("s2_done", done, 1);
    chk("s2_err", err_count, 1);
    chk("s2_ffidx", first_fail_idx, 2);
    chk("s2_ffbits", first_fail_bits, 4'b1100);
    chk("s2_fail_seen", fail_seen, 1);
    chk("s2_pass", pass, 0);

    // sample_valid in DONE is ignored
    vec(0, 0, 1, 1);
    chk("done_sv_vec", vec_count, 4);
    chk("done_sv_err", err_count, 1);

    // asynchronous reset mid-run
    pulse_start();
    vec(0, 1, 1, 1);
    vec(1, 0, 0, 1);
    chk("s4_pre_vec", vec_count, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("s4_async_busy", busy, 0);
    chk("s4_async_vec", vec_count, 0);
    chk("s4_async_err", err_count, 0);
    chk("s4_async_fail_seen", fail_seen, 0);
    chk("s4_async_ffbits", first_fail_bits, 0);
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    chk("s4_stay_idle", busy, 0);
    pulse_start();
    vec(1, 1, 1, 0);
    vec(0, 0, 0, 0);
    vec(1, 0, 0, 1);
    vec(0, 1, 0, 1);
    chk("s4_done", done, 1);
    chk("s4_pass", pass, 1);
    chk("s4_err", err_count, 0);
    chk("s4_vec", vec_count, 4);

    // narrow counters, every vector wrong
    start_s = 1'b1;
    tick();
    start_s = 1'b0;
    vec(0, 0, 1, 0);
    vec(1, 1, 0, 0);
    vec(0, 1, 1, 1);
    chk("sat_err", err_count_s, 3);
    chk("sat_done", done_s, 1);
    chk("sat_pass", pass_s, 0);
    chk("sat_vec", vec_count_s, 3);
    chk("sat_ffbits", first_fail_bits_s, 4'b0010);
    chk("sat_main_vec", vec_count, 4);

    // all-00 run: coverage gates pass only when the feature is built in
    pulse_start();
    vec(0, 0, 0, 0);
    vec(0, 0, 0, 0);
    vec(0, 0, 0, 0);
    vec(0, 0, 0, 0);
    chk("cov_done", done, 1);
    chk("cov_err", err_count, 0);
`ifdef HA_CHECK_COVERAGE_EN
    chk("cov_map", cov_map, 4'b0001);
    chk("cov_pass", pass, 0);
`else
    chk("nocov_pass", pass, 1);
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/ha_response_checker.md
HA_RESPONSE_CHECKER -- requirements
Module: ha_response_checker

Interface
REQ-001 Parameter NUM_VECTORS, default 4, SHALL set the number of vectors checked per run (legal range 1..2**CNT_W-1).
REQ-002 Parameter CNT_W, default 8, SHALL set the width of all counters and vector indices.
REQ-003 Port list SHALL be, one per line:
  clk  input  1  rising-edge clock
  rst_n  input  1  asynchronous active-low reset
  start  input  1  one-cycle pulse that begins a run
  sample_valid  input  1  a/b/c/s hold a vector for checking this cycle
  a  input  1  half-adder operand A
  b  input  1  half-adder operand B
  c  input  1  observed carry from the device under test
  s  input  1  observed sum from the device under test
  busy  output  1  run in progress
  done  output  1  run complete, held until the next start
  pass  output  1  run finished with zero mismatches, valid while done=1
  err_count  output  CNT_W  mismatches counted this run
  vec_count  output  CNT_W  vectors checked this run
  first_fail_idx  output  CNT_W  index of the first mismatching vector
  first_fail_bits  output  4  {a,b,c,s} of the first mismatching vector
  fail_seen  output  1  at least one mismatch this run

Function
REQ-004 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-005 In IDLE, start SHALL clear every counter and capture register and move the FSM to RUN on the next edge.
REQ-006 In RUN, each cycle with sample_valid=1 SHALL check one vector against expected c = a&b and expected s = a^b.
REQ-007 Each checked vector SHALL increment vec_count by 1, with the result registered one cycle after the sample.
REQ-008 A mismatch SHALL increment err_count, saturating at 2**CNT_W-1 with no wrap.
REQ-009 On the first mismatch of a run, first_fail_idx SHALL take the pre-increment vec_count and first_fail_bits SHALL take {a,b,c,s}; both SHALL then hold, and fail_seen SHALL set.
REQ-010 When the vector that makes vec_count equal NUM_VECTORS is checked, the FSM SHALL go to DONE on the same edge.
REQ-011 Entering DONE SHALL set done=1 and pass=(err_count==0, including that last vector).
REQ-012 sample_valid SHALL be ignored in IDLE and in DONE.
REQ-013 start SHALL be ignored in RUN.
REQ-014 start in DONE SHALL behave as in IDLE: clear everything and enter RUN.
REQ-015 busy SHALL be 1 exactly in RUN, and done SHALL be 1 exactly in DONE.
REQ-016 pass SHALL be 0 whenever done=0.
REQ-017 All outputs SHALL be registered, with no combinational path from inputs to outputs.

Reset
REQ-018 rst_n low SHALL asynchronously force state=IDLE and every output to 0, at any time including mid-run.
REQ-019 After rst_n deasserts, the block SHALL stay in IDLE until start.

Configuration
REQ-020 With HA_CHECK_COVERAGE_EN defined, a 4-bit output cov_map SHALL be added, with bit {a,b} set when that operand pair is checked; cov_map SHALL clear on start and on reset.
REQ-021 With HA_CHECK_COVERAGE_EN defined, pass SHALL additionally require cov_map==4'b1111.
REQ-022 Without HA_CHECK_COVERAGE_EN, cov_map SHALL be absent and pass SHALL depend only on err_count.

Structure
REQ-023 Package ha_check_pkg SHALL hold the state enum typedef (IDLE/RUN/DONE) and the constant NUM_COMBOS=4.
REQ-024 Sub-module ha_ref_model (combinational: a,b -> exp_c,exp_s) SHALL be instantiated once as the expected-value source.

Verification
REQ-025 Bench scenario, correct device: reset, start, then the 4 vectors 00,01,10,11 with correct c/s -> done=1 the cycle after the 4th vector, pass=1, err_count=0, vec_count=4, fail_seen=0.
REQ-026 Bench scenario, injected fault: vector a=1,b=1 driven with c=0,s=0 as the 3rd vector -> err_count=1, first_fail_idx=2, first_fail_bits=4'b1100, pass=0.
REQ-027 Bench scenario, ignored inputs: sample_valid pulsed in IDLE and start pulsed mid-RUN -> vec_count unaffected, run completes after exactly 4 checked vectors.
REQ-028 Bench scenario, reset mid-run: rst_n low after 2 vectors -> all outputs 0 immediately (asynchronous); a new start then runs a clean 4-vector pass.
REQ-029 Bench scenario, saturation: CNT_W=2, NUM_VECTORS=3, all 3 vectors wrong -> err_count=3, done=1.
REQ-030 Bench scenario, coverage build: with HA_CHECK_COVERAGE_EN, 4 correct vectors all 00 -> cov_map=4'b0001, pass=0.
